kara_seq_49bit: RTL

KARA_SEQ_49BIT -- requirements
Module: kara_seq_49bit

---
 rtl/kara_seq_49bit.sv | 108 ++++++++++
 1 files changed

// File: rtl/kara_seq_49bit.sv
// Sequential 49x49 GF(2) Karatsuba multiplier on one shared 25x25 carry-less multiplier.
// Result valid 3 edges after the accepting edge; it is held in DONE until out_ready, and start is ignored while busy.
module kara_seq_49bit #(
    parameter int N = 49,
    parameter int H = 25
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           busy,
    output logic [H-1:0]   mul_a,
    output logic [H-1:0]   mul_b,
    input  logic [2*H-2:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] result
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL0 = 3'd1,
        S_MUL1 = 3'd2,
        S_MUL2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2*N-2:0] r_acc;
    logic [2*N-2:0] w_acc_nxt;
    logic [2*N-2:0] w_p;
    logic [H-1:0]   w_a0;
    logic [H-1:0]   w_a1;
    logic [H-1:0]   w_b0;
    logic [H-1:0]   w_b1;
    logic           w_accept;

    assign w_a0     = r_a[H-1:0];
    assign w_a1     = {{(2*H-N){1'b0}}, r_a[N-1:H]};
    assign w_b0     = r_b[H-1:0];
    assign w_b1     = {{(2*H-N){1'b0}}, r_b[N-1:H]};
    assign w_p      = {{(2*N-2*H){1'b0}}, mul_p};
    assign w_accept = (r_state == S_IDLE) && start;

    // Karatsuba: P0 + (P0^P1^P2)x^H + P2 x^2H, with P1 = (A0^A1)(B0^B1)
    always_comb begin
        w_next    = r_state;
        mul_a     = '0;
        mul_b     = '0;
        w_acc_nxt = r_acc;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_MUL0;
            end
            S_MUL0: begin
                w_next    = S_MUL1;
                mul_a     = w_a0;
                mul_b     = w_b0;
                w_acc_nxt = r_acc ^ w_p ^ (w_p << H);
            end
            S_MUL1: begin
                w_next    = S_MUL2;
                mul_a     = w_a1;
                mul_b     = w_b1;
                w_acc_nxt = r_acc ^ (w_p << H) ^ (w_p << (2*H));
            end
            S_MUL2: begin
                w_next    = S_DONE;
                mul_a     = w_a0 ^ w_a1;
                mul_b     = w_b0 ^ w_b1;
                w_acc_nxt = r_acc ^ (w_p << H);
            end
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= a_in;
                r_b   <= b_in;
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_acc;

endmodule
